// File: rtl/burst_req_tx.sv
// burst_req_tx: host-side serial request transmitter for the burst controller.
// Takes one parallel request (mode, start address, burst length), enables the
// controller, shifts the length (burst only) and then the address out MSB
// first, and waits for the controller's completion pulse or a timeout.
//
// Handshake: a request is accepted on the rising edge where
// req_valid && req_ready; req_ready is high only in IDLE, and the request
// fields are captured on that same edge, so they may change freely afterwards.
module burst_req_tx #(
  parameter int ADDR_W  = 32,
  parameter int LEN_W   = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_mode,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  output logic              burst_en,
  output logic              burst_mode_sel,
  output logic              ser_data,
  output logic              ser_len_valid,
  output logic              ser_addr_valid,
  input  logic              burst_done,
  output logic              busy,
  output logic              tx_done,
  output logic              tx_err,
  output logic [1:0]        dbg_state
);

  localparam int MAX_W = (ADDR_W > LEN_W) ? ADDR_W : LEN_W;
  localparam int CNT_W = $clog2(MAX_W) + 1;
  localparam int TMO_W = $clog2(TIMEOUT);

  localparam logic [CNT_W-1:0] LEN_LAST  = CNT_W'(LEN_W);
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND_LEN  = 2'd1,
    SEND_ADDR = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [LEN_W-1:0]  len_sr_q, len_sr_d;
  logic [ADDR_W-1:0] addr_sr_q, addr_sr_d;
  // Number of bits already placed on the link in the current phase (1..W).
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;

  logic req_ready_q, req_ready_d;
  logic burst_en_q, burst_en_d;
  logic mode_sel_q, mode_sel_d;
  logic ser_data_q, ser_data_d;
  logic len_v_q, len_v_d;
  logic addr_v_q, addr_v_d;
  logic busy_q, busy_d;
  logic tx_done_q, tx_done_d;
  logic tx_err_q, tx_err_d;

  logic eff_mode;

  // A zero-length burst is sent as a single transfer.
  assign eff_mode = req_mode && (req_len != '0);

  // Next-state and next-output logic; every output is computed one cycle
  // ahead so that it leaves a flop.
  always_comb begin
    state_d     = state_q;
    len_sr_d    = len_sr_q;
    addr_sr_d   = addr_sr_q;
    bit_cnt_d   = bit_cnt_q;
    tmo_cnt_d   = tmo_cnt_q;
    req_ready_d = req_ready_q;
    burst_en_d  = burst_en_q;
    mode_sel_d  = mode_sel_q;
    ser_data_d  = 1'b0;
    len_v_d     = 1'b0;
    addr_v_d    = 1'b0;
    busy_d      = busy_q;
    tx_done_d   = 1'b0;
    tx_err_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          req_ready_d = 1'b0;
          busy_d      = 1'b1;
          burst_en_d  = 1'b1;
          mode_sel_d  = eff_mode;
          bit_cnt_d   = CNT_W'(1);
          if (eff_mode) begin
            state_d    = SEND_LEN;
            len_v_d    = 1'b1;
            ser_data_d = req_len[LEN_W-1];
            len_sr_d   = req_len << 1;
            addr_sr_d  = req_addr;
          end else begin
            state_d    = SEND_ADDR;
            addr_v_d   = 1'b1;
            ser_data_d = req_addr[ADDR_W-1];
            len_sr_d   = '0;
            addr_sr_d  = req_addr << 1;
          end
        end
      end

      SEND_LEN: begin
        if (bit_cnt_q == LEN_LAST) begin
          // Last length bit is on the link; address MSB follows with no gap.
          state_d    = SEND_ADDR;
          addr_v_d   = 1'b1;
          ser_data_d = addr_sr_q[ADDR_W-1];
          addr_sr_d  = addr_sr_q << 1;
          bit_cnt_d  = CNT_W'(1);
        end else begin
          len_v_d    = 1'b1;
          ser_data_d = len_sr_q[LEN_W-1];
          len_sr_d   = len_sr_q << 1;
          bit_cnt_d  = bit_cnt_q + CNT_W'(1);
        end
      end

      SEND_ADDR: begin
        if (bit_cnt_q == ADDR_LAST) begin
          state_d   = WAIT_DONE;
          tmo_cnt_d = '0;
        end else begin
          addr_v_d   = 1'b1;
          ser_data_d = addr_sr_q[ADDR_W-1];
          addr_sr_d  = addr_sr_q << 1;
          bit_cnt_d  = bit_cnt_q + CNT_W'(1);
        end
      end

      WAIT_DONE: begin
        // Completion takes priority over a timeout expiring in the same cycle.
        if (burst_done || (tmo_cnt_q == TMO_LAST)) begin
          state_d     = IDLE;
          req_ready_d = 1'b1;
          busy_d      = 1'b0;
          burst_en_d  = 1'b0;
          mode_sel_d  = 1'b0;
          bit_cnt_d   = '0;
          tmo_cnt_d   = '0;
          tx_done_d   = burst_done;
          tx_err_d    = ~burst_done;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, datapath and registered outputs; reset aborts any transfer silently.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      len_sr_q    <= '0;
      addr_sr_q   <= '0;
      bit_cnt_q   <= '0;
      tmo_cnt_q   <= '0;
      req_ready_q <= 1'b1;
      burst_en_q  <= 1'b0;
      mode_sel_q  <= 1'b0;
      ser_data_q  <= 1'b0;
      len_v_q     <= 1'b0;
      addr_v_q    <= 1'b0;
      busy_q      <= 1'b0;
      tx_done_q   <= 1'b0;
      tx_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_sr_q    <= len_sr_d;
      addr_sr_q   <= addr_sr_d;
      bit_cnt_q   <= bit_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      req_ready_q <= req_ready_d;
      burst_en_q  <= burst_en_d;
      mode_sel_q  <= mode_sel_d;
      ser_data_q  <= ser_data_d;
      len_v_q     <= len_v_d;
      addr_v_q    <= addr_v_d;
      busy_q      <= busy_d;
      tx_done_q   <= tx_done_d;
      tx_err_q    <= tx_err_d;
    end
  end

  assign req_ready      = req_ready_q;
  assign burst_en       = burst_en_q;
  assign burst_mode_sel = mode_sel_q;
  assign ser_data       = ser_data_q;
  assign ser_len_valid  = len_v_q;
  assign ser_addr_valid = addr_v_q;
  assign busy           = busy_q;
  assign tx_done        = tx_done_q;
  assign tx_err         = tx_err_q;
  assign dbg_state      = state_q;

endmodule
